// File: rtl/aes_iter_core.sv
// Iterative AES-128/AES-256 encryption core: one round per clock, round keys expanded on the fly.
// Blocks are accepted in IDLE and run through ROUND. The ciphertext is then held in HOLD until the consumer takes it.
module aes_iter_core #(
    parameter int KEY_BITS = 128,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        state,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out,
    output logic                busy,
    output logic [CNT_W-1:0]    block_cnt
);

    localparam int NR = (KEY_BITS == 256) ? 14 : 10;

    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, HOLD = 2'd2} fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [127:0]        data_q, data_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [127:0]        out_q, out_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q, out_valid_q, busy_q;
    logic [127:0]        rk_s;
    logic [KEY_BITS-1:0] key_nx_s;
    logic [127:0]        round_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            else      p = p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, b;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        b    = gmul(gmul(x240, x12), x2);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Next four key words from the four words Nk positions back and the newest word.
    function automatic logic [127:0] expand_half(input logic [127:0] prev, input logic [31:0] last,
                                                 input logic rot, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        if (rot) t = sub_word({last[23:0], last[31:24]}) ^ {rc, 24'h000000};
        else     t = sub_word(last);
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64] ^ w0;
        w2 = prev[63:32] ^ w1;
        w3 = prev[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int j = 0; j < 16; j++) sb[j] = sbox(s[127-8*j -: 8]);
        for (int j = 0; j < 16; j++) t[j] = sb[4*(((j/4)+(j%4))%4)+(j%4)];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c];
            a1 = t[4*c+1];
            a2 = t[4*c+2];
            a3 = t[4*c+3];
            if (last) r[127-32*c -: 32] = {a0, a1, a2, a3};
            else      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    generate
        if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
            $error("aes_iter_core: KEY_BITS must be 128 or 256");
        end
        if (KEY_BITS == 256) begin : g_k256
            // Low half is the current round key; odd rounds create a RotWord+Rcon half, even rounds a SubWord-only half.
            logic [127:0] new_half_s;
            always_comb begin
                new_half_s = expand_half(key_q[255:128], key_q[31:0], rnd_q[0],
                                         rcon({1'b0, rnd_q[3:1]} + 4'd1));
            end
            assign rk_s     = key_q[127:0];
            assign key_nx_s = {key_q[127:0], new_half_s};
        end else begin : g_k128
            assign rk_s     = expand_half(key_q[127:0], key_q[31:0], 1'b1, rcon(rnd_q));
            assign key_nx_s = rk_s;
        end
    endgenerate

    assign round_s = round_fn(data_q, rnd_q == 4'(NR)) ^ rk_s;

    // Next-state logic for FSM, datapath and delivered-block counter.
    always_comb begin
        fsm_d  = fsm_q;
        data_d = data_q;
        key_d  = key_q;
        rnd_d  = rnd_q;
        out_d  = out_q;
        cnt_d  = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    data_d = state ^ key[KEY_BITS-1 -: 128];
                    key_d  = key;
                    rnd_d  = 4'd1;
                    fsm_d  = ROUND;
                end else begin
                    fsm_d = IDLE;
                end
            end
            ROUND: begin
                data_d = round_s;
                key_d  = key_nx_s;
                if (rnd_q == 4'(NR)) begin
                    out_d = round_s;
                    rnd_d = 4'd0;
                    fsm_d = HOLD;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_d = 128'h0;
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    fsm_d = IDLE;
                end else begin
                    fsm_d = HOLD;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            data_q      <= 128'h0;
            key_q       <= {KEY_BITS{1'b0}};
            rnd_q       <= 4'd0;
            out_q       <= 128'h0;
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            data_q      <= data_d;
            key_q       <= key_d;
            rnd_q       <= rnd_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (fsm_d == IDLE);
            out_valid_q <= (fsm_d == HOLD);
            busy_q      <= (fsm_d != IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign busy      = busy_q;
    assign block_cnt = cnt_q;

endmodule
